// File: rtl/serial_comparator_ctrl.sv
// Bit-serial magnitude compare controller. It walks two latched operands MSB-first
// through an external one-bit comparator and stops early at the first differing bit.
// Handshake: start is a request that is taken only in IDLE (busy=0). The result flags
// are valid when done pulses and hold until the next accepted start or reset.
module serial_comparator_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ca,
    output logic         cb,
    input  logic         cg,
    input  logic         ce,
    input  logic         cl,
    output logic         busy,
    output logic         done,
    output logic         g,
    output logic         e,
    output logic         l,
    output logic         err
);

    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  ra, rb, ra_n, rb_n;
    logic [IW-1:0] idx, idx_n;
    logic          g_n, e_n, l_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= '0;
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ra    <= ra_n;
            rb    <= rb_n;
            idx   <= idx_n;
            g     <= g_n;
            e     <= e_n;
            l     <= l_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        ra_n    = ra;
        rb_n    = rb;
        idx_n   = idx;
        g_n     = g;
        e_n     = e;
        l_n     = l;
        err_n   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    ra_n    = a;
                    rb_n    = b;
                    idx_n   = IW'(W - 1);
                    g_n     = 1'b0;
                    e_n     = 1'b0;
                    l_n     = 1'b0;
                    err_n   = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // Flags were cleared on acceptance, so only the winning flag is set here.
                case ({cg, ce, cl})
                    3'b100: begin
                        g_n     = 1'b1;
                        state_n = DONE;
                    end
                    3'b001: begin
                        l_n     = 1'b1;
                        state_n = DONE;
                    end
                    3'b010: begin
                        if (idx == '0) begin
                            e_n     = 1'b1;
                            state_n = DONE;
                        end else begin
                            idx_n = idx - IW'(1);
                        end
                    end
                    default: begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end
                endcase
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
    assign ca   = (state == RUN) ? ra[idx] : 1'b0;
    assign cb   = (state == RUN) ? rb[idx] : 1'b0;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Randomized bench for serial_comparator_ctrl: a word-level compare model predicts
// the flags and latency of each operation, with an ideal or faulty bit comparator.
module tb_serial_comparator_ctrl;

    localparam int W = 8;

    logic         clk, rst, start;
    logic [W-1:0] a, b;
    logic         ca, cb, cg, ce, cl;
    logic         busy, done, g, e, l, err;
    logic         fault;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    int         lat_q[$];

    serial_comparator_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ca(ca), .cb(cb), .cg(cg), .ce(ce), .cl(cl),
        .busy(busy), .done(done), .g(g), .e(e), .l(l), .err(err)
    );

    // External one-bit comparator; the fault mode drives cg and ce high together.
    assign cg = fault | (ca & ~cb);
    assign ce = fault | (ca ~^ cb);
    assign cl = ~fault & (~ca & cb);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Word-level reference: the first differing bit from the top decides the result.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic flt);
        int k;
        logic [3:0] f;
        if (flt) begin
            k = 1;
            f = 4'b0001;
        end else if (av == bv) begin
            k = W;
            f = 4'b0100;
        end else begin
            k = 0;
            for (int i = W - 1; i >= 0; i--)
                if (k == 0 && av[i] != bv[i]) k = W - i;
            f = (av > bv) ? 4'b1000 : 4'b0010;
        end
        exp_q.push_back(f);
        lat_q.push_back(k + 1);
    endtask

    // Entered at the negedge of RUN cycle 1; returns at the negedge of the IDLE cycle after DONE.
    task automatic wait_done(input logic [W-1:0] av, input logic [W-1:0] bv);
        int cyc;
        logic [3:0] f;
        int lat;
        f   = exp_q.pop_front();
        lat = lat_q.pop_front();
        cyc = 1;
        while (!done && cyc <= W + 2) begin
            check("busy_run", busy, 1);
            if (cyc <= W) begin
                check("ca_bit", ca, av[W-cyc]);
                check("cb_bit", cb, bv[W-cyc]);
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        check("latency", cyc, lat);
        check("flags", {g, e, l, err}, f);
        check("busy_done", busy, 1);
        check("cab_done", {ca, cb}, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("cab_idle", {ca, cb}, 0);
        check("flags_hold", {g, e, l, err}, f);
        fault = 1'b0;
    endtask

    // Called at a negedge while IDLE; scrambles a/b after acceptance.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic flt);
        model(av, bv, flt);
        start = 1'b1;
        a     = av;
        b     = bv;
        fault = flt;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(av, bv);
    endtask

    always @(negedge clk)
        if (!rst) check("at_most_one_flag", ($countones({g, e, l, err}) <= 1), 1);

    initial begin
        logic [W-1:0] av, bv;
        logic [W-1:0] hav[4], hbv[4];
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {busy, done, g, e, l, err, ca, cb}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'h12, 8'h13, 1'b0);
        run_op(8'h3C, 8'h5A, 1'b1);

        // Reset in RUN cycle 4 aborts; start on the first edge after rst falls.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("no_done_before_rst", done, 0);
            if (c < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {busy, done, g, e, l, err, ca, cb}, 0);
        run_op(8'h01, 8'h00, 1'b0);

        // Reset wins over start on the same edge.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_over_start", busy, 0);
        @(negedge clk);
        check("rst_over_start_idle", busy, 0);

        // Start held high: each DONE is followed by one IDLE cycle, then the next op.
        for (int i = 0; i < 4; i++) begin
            hav[i] = W'($urandom);
            hbv[i] = (i == 1) ? hav[i] : W'($urandom);
        end
        start = 1'b1;
        a     = hav[0];
        b     = hbv[0];
        for (int i = 0; i < 4; i++) begin
            model(hav[i], hbv[i], 1'b0);
            @(negedge clk);
            if (i < 3) begin
                a = hav[i+1];
                b = hbv[i+1];
            end else begin
                start = 1'b0;
            end
            wait_done(hav[i], hbv[i]);
        end

        for (int i = 0; i < 40; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            run_op(av, bv, ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
